// File: rtl/sensor_debouncer.sv
// Two-channel synchronizer + debouncer for the barrier sensors.
// Each channel: 2-flop synchronizer, STABLE/COUNTING debounce FSM,
// registered clean level and single-cycle rise/fall pulses.
module sensor_debouncer #(
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_A_raw,
  input  logic btn_B_raw,
  output logic btn_A,
  output logic btn_B,
  output logic A_rise,
  output logic A_fall,
  output logic B_rise,
  output logic B_fall,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {STABLE, COUNTING} state_t;

  // Channel 0 is A, channel 1 is B.
  logic [1:0] raw;
  logic [1:0] clean;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] cnt_nz;

  assign raw = {btn_B_raw, btn_A_raw};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic           s1;
    logic           s2;
    state_t         state;
    state_t         state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic           clean_q;
    logic           clean_nxt;
    logic           rise_q;
    logic           rise_nxt;
    logic           fall_q;
    logic           fall_nxt;

    // Two-flop synchronizer for the asynchronous raw input.
    always_ff @(posedge clk) begin
      if (!rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
      end
    end

    // Debounce state, counter, clean level and pulse registers.
    always_ff @(posedge clk) begin
      if (!rst) begin
        state   <= STABLE;
        cnt     <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        clean_q <= clean_nxt;
        rise_q  <= rise_nxt;
        fall_q  <= fall_nxt;
      end
    end

    // Next-state: any disagreement-free cycle restarts, N disagreeing samples confirm.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clean_nxt = clean_q;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
        STABLE: begin
          if (s2 != clean_q) begin
            state_nxt = COUNTING;
            cnt_nxt   = CNT_ONE;
          end
        end
        COUNTING: begin
          if (s2 == clean_q) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
            clean_nxt = s2;
            rise_nxt  = s2;
            fall_nxt  = ~s2;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign clean[g]  = clean_q;
    assign rise[g]   = rise_q;
    assign fall[g]   = fall_q;
    assign cnt_nz[g] = (cnt != '0);
  end

  assign btn_A  = clean[0];
  assign btn_B  = clean[1];
  assign A_rise = rise[0];
  assign A_fall = fall[0];
  assign B_rise = rise[1];
  assign B_fall = fall[1];
  assign busy   = |cnt_nz;

endmodule

// File: tb/tb_sensor_debouncer.sv
// Scoreboard bench for sensor_debouncer: a window-based reference model
// predicts every cycle's outputs; a monitor pops and compares them.
module tb_sensor_debouncer;

  localparam int N    = 8;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic btn_A, btn_B, A_rise, A_fall, B_rise, B_fall, busy;

  always #5 clk = ~clk;

  sensor_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_A_raw(a_raw),
    .btn_B_raw(b_raw),
    .btn_A    (btn_A),
    .btn_B    (btn_B),
    .A_rise   (A_rise),
    .A_fall   (A_fall),
    .B_rise   (B_rise),
    .B_fall   (B_fall),
    .busy     (busy)
  );

  // Reference model state: synchronizer stages, history of the value the
  // debouncer sees at each edge, clean level, and edge of last reset/change.
  bit   m_s1 [2];
  bit   m_s2 [2];
  bit   m_clean [2];
  int   last_ev [2];
  bit   hist [2][MAXC];
  int   t = 0;

  logic [6:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int mon_cycle = 0;

  // Predict outputs after the upcoming rising edge and queue them.
  task automatic model_step(input bit ra, input bit rb, input bit rn);
    bit raw_v [2];
    bit rs [2];
    bit fl [2];
    bit bs [2];
    raw_v[0] = ra;
    raw_v[1] = rb;
    for (int c = 0; c < 2; c++) begin
      rs[c] = 1'b0;
      fl[c] = 1'b0;
      bs[c] = 1'b0;
      if (!rn) begin
        m_s1[c] = 1'b0;
        m_s2[c] = 1'b0;
        m_clean[c] = 1'b0;
        last_ev[c] = t;
      end else begin
        bit all_diff;
        int run;
        hist[c][t] = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raw_v[c];
        // Confirm when the last N samples since the last event all differ.
        all_diff = ((t - last_ev[c]) >= N);
        if (all_diff) begin
          for (int i = 0; i < N; i++) begin
            if (hist[c][t-i] == m_clean[c]) all_diff = 1'b0;
          end
        end
        if (all_diff) begin
          m_clean[c] = ~m_clean[c];
          rs[c] = m_clean[c];
          fl[c] = ~m_clean[c];
          last_ev[c] = t;
        end
        // Pending change: trailing run of disagreeing samples since last event.
        run = 0;
        for (int i = 0; i < N; i++) begin
          if ((t - i) <= last_ev[c]) break;
          if (hist[c][t-i] == m_clean[c]) break;
          run++;
        end
        bs[c] = (run > 0);
      end
    end
    exp_q.push_back({m_clean[0], m_clean[1], rs[0], fl[0], rs[1], fl[1], bs[0] | bs[1]});
    t++;
    if (t >= MAXC) begin
      $display("FAIL model_budget: cycle %0d exceeds limit %0d", t, MAXC);
      $fatal(1, "model history exhausted");
    end
  endtask

  task automatic drive(input bit a, input bit b, input bit rn, input int n);
    repeat (n) begin
      @(negedge clk);
      a_raw = a;
      b_raw = b;
      rst   = rn;
      model_step(a, b, rn);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against queued prediction.
  always @(posedge clk) begin
    logic [6:0] exp_v;
    logic [6:0] act_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {btn_A, btn_B, A_rise, A_fall, B_rise, B_fall, busy};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL outputs cycle %0d {A,B,Ar,Af,Br,Bf,busy}: got %b expected %b",
                 mon_cycle, act_v, exp_v);
      end
      mon_cycle++;
    end
  end

  initial begin
    bit ra, rb, rn;
    int len;
    // Reset held with both inputs high, then release.
    drive(1, 1, 0, 3);
    drive(1, 1, 1, 20);
    drive(0, 0, 1, 20);
    // Clean press on A.
    drive(1, 0, 1, 20);
    // Bounce on B while A stays high.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 3);
      drive(1, 0, 1, 3);
    end
    drive(1, 0, 1, 20);
    // Near-miss glitch (N-1 cycles) then just-enough (N cycles).
    drive(0, 0, 1, 20);
    drive(1, 0, 1, N - 1);
    drive(0, 0, 1, 20);
    drive(1, 0, 1, N);
    drive(0, 0, 1, 20);
    // Entry sequence.
    drive(1, 0, 1, 100);
    drive(1, 1, 1, 100);
    drive(0, 1, 1, 100);
    drive(0, 0, 1, 100);
    // Simultaneous rise, then reset in the middle of A's falling count.
    drive(1, 1, 1, 20);
    drive(0, 1, 1, 4);
    drive(0, 1, 0, 1);
    drive(0, 1, 1, 20);
    // Randomized bouncing segments with occasional resets.
    for (int s = 0; s < 80; s++) begin
      ra  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      rn  = ($urandom_range(0, 24) != 0);
      len = rn ? int'($urandom_range(1, 14)) : 1;
      drive(ra, rb, rn, len);
    end
    drive(0, 0, 1, 15);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
